// File: rtl/interrupt_request_arbiter_pkg.sv
// Shared definitions for the interrupt request arbiter: FSM encoding and
// default source count.
package interrupt_request_arbiter_pkg;

   localparam int unsigned NUM_SRC_DEFAULT = 4;
   localparam int unsigned ID_W_DEFAULT    = $clog2(NUM_SRC_DEFAULT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/interrupt_request_arbiter_if.sv
// Peripheral/core signal bundle of the interrupt request arbiter.
interface interrupt_request_arbiter_if
   import interrupt_request_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = NUM_SRC_DEFAULT,
   parameter int unsigned ID_W    = $clog2(NUM_SRC)
);

   logic [NUM_SRC-1:0] irq_in;
   logic [NUM_SRC-1:0] irq_mask;
   logic               ret_ISR;
   logic               interrupt_signal;
   logic [ID_W-1:0]    irq_id;
   logic [NUM_SRC-1:0] irq_pending;
   logic               in_service;

   modport master (
      output irq_in, irq_mask, ret_ISR,
      input  interrupt_signal, irq_id, irq_pending, in_service
   );

   modport slave (
      input  irq_in, irq_mask, ret_ISR,
      output interrupt_signal, irq_id, irq_pending, in_service
   );

endinterface

// File: rtl/irq_priority_encoder.sv
// Combinational fixed-priority encoder; the lowest set index wins.
module irq_priority_encoder
   import interrupt_request_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = NUM_SRC_DEFAULT,
   parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] eligible,
   output logic               valid,
   output logic [ID_W-1:0]    index
);

   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (eligible[i] && !valid) begin
            valid = 1'b1;
            index = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/interrupt_request_arbiter.sv
// Edge-triggered interrupt arbiter: edge detect, pending register and a
// non-nesting IDLE/REQ/SERVICE handshake with the core.
module interrupt_request_arbiter
   import interrupt_request_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = NUM_SRC_DEFAULT,
   parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
   input  logic                        clk,
   input  logic                        rst,
   interrupt_request_arbiter_if.slave  bus
);

   arb_state_t         state;
   logic [NUM_SRC-1:0] irq_prev;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] grant_clr;
   logic               enc_valid;
   logic [ID_W-1:0]    enc_index;
   logic               int_q;
   logic [ID_W-1:0]    id_q;
   logic               svc_q;

   irq_priority_encoder #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_enc (
      .eligible (eligible),
      .valid    (enc_valid),
      .index    (enc_index)
   );

   always_comb begin
      rise      = bus.irq_in & ~irq_prev;
      eligible  = pending & bus.irq_mask;
      grant_clr = '0;
      if (state == IDLE && enc_valid) begin
         grant_clr[enc_index] = 1'b1;
      end
   end

   // A new edge on the bit being granted re-arms it in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_prev <= '0;
         pending  <= '0;
      end else begin
         irq_prev <= bus.irq_in;
         pending  <= (pending & ~grant_clr) | rise;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         int_q <= 1'b0;
         id_q  <= '0;
         svc_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enc_valid) begin
                  state <= REQ;
                  int_q <= 1'b1;
                  id_q  <= enc_index;
                  svc_q <= 1'b1;
               end
            end
            REQ: begin
               state <= SERVICE;
               int_q <= 1'b0;
            end
            SERVICE: begin
               if (bus.ret_ISR) begin
                  state <= IDLE;
                  svc_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               int_q <= 1'b0;
               svc_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.interrupt_signal = int_q;
   assign bus.irq_id           = id_q;
   assign bus.irq_pending      = pending;
   assign bus.in_service       = svc_q;

endmodule

// File: tb/tb_interrupt_request_arbiter.sv
// Directed self-checking bench for interrupt_request_arbiter.
module tb_interrupt_request_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   interrupt_request_arbiter_if #(.NUM_SRC(4), .ID_W(2)) bus ();

   interrupt_request_arbiter #(.NUM_SRC(4), .ID_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic i_sig, input logic [1:0] id,
                          input logic [3:0] pend, input logic svc);
      chk({tag, ".int"},  32'(bus.interrupt_signal), 32'(i_sig));
      chk({tag, ".id"},   32'(bus.irq_id),           32'(id));
      chk({tag, ".pend"}, 32'(bus.irq_pending),      32'(pend));
      chk({tag, ".svc"},  32'(bus.in_service),       32'(svc));
   endtask

   initial begin
      bus.irq_in   = '0;
      bus.irq_mask = 4'hF;
      bus.ret_ISR  = 1'b0;

      // reset state
      tick();
      tick();
      chk_all("rst_hold", 1'b0, 2'd0, 4'h0, 1'b0);
      rst = 1'b0;
      tick();
      chk_all("rst_rel", 1'b0, 2'd0, 4'h0, 1'b0);

      // single source
      bus.irq_in = 4'b0100;
      tick();
      chk_all("single_t0", 1'b0, 2'd0, 4'b0100, 1'b0);
      tick();
      chk_all("single_t1", 1'b1, 2'd2, 4'b0000, 1'b1);
      tick();
      chk_all("single_t2", 1'b0, 2'd2, 4'b0000, 1'b1);
      tick();
      tick();
      chk_all("single_hold", 1'b0, 2'd2, 4'b0000, 1'b1);
      bus.ret_ISR = 1'b1;
      tick();
      chk_all("single_ret", 1'b0, 2'd2, 4'b0000, 1'b0);
      bus.ret_ISR = 1'b0;
      bus.irq_in  = 4'b0000;
      tick();
      chk_all("single_idle", 1'b0, 2'd2, 4'b0000, 1'b0);

      // simultaneous sources
      bus.irq_in = 4'b1010;
      tick();
      chk_all("simul_t0", 1'b0, 2'd2, 4'b1010, 1'b0);
      tick();
      chk_all("simul_g1", 1'b1, 2'd1, 4'b1000, 1'b1);
      tick();
      chk_all("simul_svc1", 1'b0, 2'd1, 4'b1000, 1'b1);
      bus.ret_ISR = 1'b1;
      tick();
      chk_all("simul_ret1", 1'b0, 2'd1, 4'b1000, 1'b0);
      bus.ret_ISR = 1'b0;
      tick();
      chk_all("simul_g2", 1'b1, 2'd3, 4'b0000, 1'b1);
      tick();
      bus.ret_ISR = 1'b1;
      tick();
      bus.ret_ISR = 1'b0;
      bus.irq_in  = 4'b0000;
      tick();
      chk_all("simul_done", 1'b0, 2'd3, 4'b0000, 1'b0);

      // masked source retained, then released
      bus.irq_mask = 4'b1110;
      bus.irq_in   = 4'b0001;
      tick();
      chk_all("mask_t0", 1'b0, 2'd3, 4'b0001, 1'b0);
      tick();
      tick();
      chk_all("mask_held", 1'b0, 2'd3, 4'b0001, 1'b0);
      bus.irq_mask = 4'hF;
      tick();
      chk_all("mask_grant", 1'b1, 2'd0, 4'b0000, 1'b1);
      tick();
      bus.ret_ISR = 1'b1;
      tick();
      bus.ret_ISR = 1'b0;
      bus.irq_in  = 4'b0000;
      tick();
      chk_all("mask_done", 1'b0, 2'd0, 4'b0000, 1'b0);

      // set/clear collision: second rise of irq_in[1] lands on its grant edge
      bus.irq_mask = 4'b1101;
      bus.irq_in   = 4'b0010;
      tick();
      chk_all("coll_rise1", 1'b0, 2'd0, 4'b0010, 1'b0);
      bus.irq_in = 4'b0000;
      tick();
      chk_all("coll_fall", 1'b0, 2'd0, 4'b0010, 1'b0);
      bus.irq_mask = 4'hF;
      bus.irq_in   = 4'b0010;
      tick();
      chk_all("coll_grant", 1'b1, 2'd1, 4'b0010, 1'b1);
      tick();
      bus.ret_ISR = 1'b1;
      tick();
      chk_all("coll_ret", 1'b0, 2'd1, 4'b0010, 1'b0);
      bus.ret_ISR = 1'b0;
      tick();
      chk_all("coll_grant2", 1'b1, 2'd1, 4'b0000, 1'b1);
      tick();
      bus.ret_ISR = 1'b1;
      tick();
      bus.ret_ISR = 1'b0;
      tick();
      tick();
      chk_all("level_once", 1'b0, 2'd1, 4'b0000, 1'b0);
      bus.irq_in = 4'b0000;
      tick();

      // stray return in IDLE and REQ
      bus.ret_ISR = 1'b1;
      tick();
      chk_all("stray_idle", 1'b0, 2'd1, 4'b0000, 1'b0);
      bus.irq_in = 4'b0001;
      tick();
      chk_all("stray_t0", 1'b0, 2'd1, 4'b0001, 1'b0);
      tick();
      chk_all("stray_req", 1'b1, 2'd0, 4'b0000, 1'b1);
      tick();
      chk_all("stray_svc", 1'b0, 2'd0, 4'b0000, 1'b1);
      bus.ret_ISR = 1'b0;
      tick();
      chk_all("stray_hold", 1'b0, 2'd0, 4'b0000, 1'b1);
      bus.ret_ISR = 1'b1;
      tick();
      chk_all("stray_ret", 1'b0, 2'd0, 4'b0000, 1'b0);
      bus.ret_ISR = 1'b0;
      bus.irq_in  = 4'b0000;
      tick();

      // asynchronous reset mid-service with a pending source
      bus.irq_in = 4'b0001;
      tick();
      tick();
      bus.irq_in = 4'b0101;
      tick();
      chk_all("mid_svc", 1'b0, 2'd0, 4'b0100, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 1'b0, 2'd0, 4'b0000, 1'b0);
      bus.irq_in = 4'b0000;
      tick();
      @(negedge clk);
      rst = 1'b0;
      tick();
      tick();
      tick();
      chk_all("post_rst", 1'b0, 2'd0, 4'b0000, 1'b0);

      // line held high through reset release yields one edge
      bus.irq_in = 4'b0100;
      rst = 1'b1;
      tick();
      chk_all("hi_rst", 1'b0, 2'd0, 4'b0000, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk_all("hi_edge", 1'b0, 2'd0, 4'b0100, 1'b0);
      tick();
      chk_all("hi_grant", 1'b1, 2'd2, 4'b0000, 1'b1);
      tick();
      bus.ret_ISR = 1'b1;
      tick();
      bus.ret_ISR = 1'b0;
      tick();
      tick();
      chk_all("hi_done", 1'b0, 2'd2, 4'b0000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/interrupt_request_arbiter.md
INTERRUPT_REQUEST_ARBITER -- requirements
Module: interrupt_request_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of peripheral interrupt sources (2..8).
REQ-002 Parameter ID_W, default 2, width of the source ID, equal to clog2(NUM_SRC).
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 irq_in  input  NUM_SRC  peripheral interrupt lines, level, synchronous to clk.
REQ-006 irq_mask  input  NUM_SRC  1 = source enabled, 0 = source masked.
REQ-007 ret_ISR  input  1  core-side return-from-ISR indication, 1-cycle pulse.
REQ-008 interrupt_signal  output  1  interrupt request pulse to the core interrupt controller.
REQ-009 irq_id  output  ID_W  index of the source being serviced.
REQ-010 irq_pending  output  NUM_SRC  pending-bit register, visible to software and debug.
REQ-011 in_service  output  1  high from request issue until ISR return.

Function
REQ-012 The block SHALL detect the rising edge of each irq_in bit against a registered copy of the previous cycle's value.
REQ-013 A detected edge SHALL set the matching irq_pending bit at the same clock edge, regardless of irq_mask.
REQ-014 An eligible source SHALL be one whose irq_pending and irq_mask bits are both 1; masked pending bits SHALL be retained.
REQ-015 Priority SHALL be fixed, with the lowest index highest.
REQ-016 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-017 IDLE: if any source is eligible at a clock edge, the FSM SHALL enter REQ at that edge, load irq_id with the winning index, and clear that source's pending bit.
REQ-018 REQ: interrupt_signal SHALL be 1 for exactly this one cycle, and the FSM SHALL enter SERVICE unconditionally at the next edge.
REQ-019 SERVICE: the FSM SHALL hold until ret_ISR=1 is sampled, then enter IDLE at that edge.
REQ-020 ret_ISR SHALL be ignored in IDLE and REQ.
REQ-021 in_service SHALL be 1 in REQ and SERVICE and 0 in IDLE.
REQ-022 irq_id SHALL hold its value from REQ entry until the next REQ entry.
REQ-023 Latency: an edge sampled at edge t0 SHALL produce interrupt_signal=1 during cycle t1..t2 when the FSM is in IDLE and no higher-priority source is eligible.
REQ-024 Edges arriving during REQ or SERVICE SHALL set pending bits; the next request SHALL issue no earlier than one cycle after SERVICE exits to IDLE.
REQ-025 When a new edge and a grant-clear hit the same bit in the same cycle, the set SHALL win and the bit SHALL remain 1.
REQ-026 A level held high SHALL produce only one pending set; a new request requires the line to fall and rise again.
REQ-027 Interrupt nesting is not supported: at most one source SHALL be in service at any time.

Reset
REQ-028 When rst=1, the block SHALL immediately force state=IDLE, interrupt_signal=0, irq_id=0, irq_pending=0, in_service=0, and previous-irq_in=0.
REQ-029 Reset asserted mid-service SHALL discard all pending and in-service status; the bench SHALL not expect any request after reset without a fresh edge.
REQ-030 Because previous-irq_in resets to 0, a line held high through reset release SHALL register one edge on the first clock after release.

Structure
REQ-031 The FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2) and the NUM_SRC default SHALL live in the shared core definitions package.
REQ-032 A combinational fixed-priority encoder SHALL be a sub-module named irq_priority_encoder, with inputs eligible[NUM_SRC-1:0] and outputs valid and index[ID_W-1:0].
REQ-033 All remaining logic, including edge detect, pending register and FSM, SHALL be in a single top module.

Verification
REQ-034 Single source: mask=4'hF, irq_in[2] rises at t0 -> interrupt_signal=1 at t1 only, irq_id=2, pending=0 at t1; ret_ISR pulse at t5 -> in_service=0 at t6.
REQ-035 Simultaneous sources: irq_in 4'b0000 -> 4'b1010 in one cycle -> irq_id=1 first; after ret_ISR, second request with irq_id=3 one cycle after IDLE is re-entered.
REQ-036 Mask: mask=4'b1110, irq_in[0] rises -> pending=4'b0001 and no request; mask set to 4'hF -> request with irq_id=0 on the next cycle.
REQ-037 Set/clear collision: irq_in[1] pulses (rise, fall, rise) so that its second rise lands in the grant cycle -> pending[1] stays 1, and a second request with irq_id=1 follows the ISR return.
REQ-038 Reset mid-service: in SERVICE with pending=4'b0100, rst=1 asynchronously between clock edges -> all outputs 0 immediately, and no request after release while irq_in=0.
REQ-039 Stray return: ret_ISR=1 in IDLE and in REQ -> no state change, and the REQ-to-SERVICE transition still occurs.
